// File: rtl/rv_csr_req_if.sv
// CSR request bus between the decode stage, the CSR file and the writeback port.
// slave : used by rv_csr_req (takes requests, drives CSR strobes and writeback).
// master: used by the requester / environment side.
// Signals: request (i_valid/o_ready, funct3, CSR index, rs1 index/data, rd),
//          CSR file port (o_csr_*, i_csr_data/i_csr_read),
//          writeback (o_wb_valid/rd/data, i_wb_ready), status (o_illegal, o_timeout, o_busy).
interface rv_csr_req_if;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned IDX_W = 12;
    localparam int unsigned REG_W = 5;

    logic             i_valid;
    logic             o_ready;
    logic [2:0]       i_funct3;
    logic [IDX_W-1:0] i_csr_idx;
    logic [REG_W-1:0] i_rs1_idx;
    logic [XLEN-1:0]  i_rs1_data;
    logic [REG_W-1:0] i_rd_idx;

    logic [IDX_W-1:0] o_csr_idx;
    logic [REG_W-1:0] o_csr_imm;
    logic             o_csr_imm_sel;
    logic             o_csr_write;
    logic             o_csr_set;
    logic             o_csr_clear;
    logic             o_csr_read;
    logic [XLEN-1:0]  o_csr_wdata;
    logic [XLEN-1:0]  i_csr_data;
    logic             i_csr_read;

    logic             o_wb_valid;
    logic [REG_W-1:0] o_wb_rd;
    logic [XLEN-1:0]  o_wb_data;
    logic             i_wb_ready;

    logic             o_illegal;
    logic             o_timeout;
    logic             o_busy;

    modport slave (
        input  i_valid, i_funct3, i_csr_idx, i_rs1_idx, i_rs1_data, i_rd_idx,
        input  i_csr_data, i_csr_read, i_wb_ready,
        output o_ready, o_csr_idx, o_csr_imm, o_csr_imm_sel,
        output o_csr_write, o_csr_set, o_csr_clear, o_csr_read, o_csr_wdata,
        output o_wb_valid, o_wb_rd, o_wb_data, o_illegal, o_timeout, o_busy
    );

    modport master (
        output i_valid, i_funct3, i_csr_idx, i_rs1_idx, i_rs1_data, i_rd_idx,
        output i_csr_data, i_csr_read, i_wb_ready,
        input  o_ready, o_csr_idx, o_csr_imm, o_csr_imm_sel,
        input  o_csr_write, o_csr_set, o_csr_clear, o_csr_read, o_csr_wdata,
        input  o_wb_valid, o_wb_rd, o_wb_data, o_illegal, o_timeout, o_busy
    );
endinterface

// File: rtl/rv_csr_req.sv
// CSR instruction sequencer: accepts one CSRRx request, checks legality, issues a
// single-cycle operation to the CSR file, waits (bounded) for the old CSR value
// and writes it back to rd.
// Ports: i_clk, i_reset (async, active-high), bus (rv_csr_req_if.slave).
// Parameter RSP_TIMEOUT: cycles after issue allowed for i_csr_read (2..15).
module rv_csr_req #(
    parameter int unsigned RSP_TIMEOUT = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    rv_csr_req_if.slave  bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned IDX_W = 12;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 4;
    // Counter value in the last WAIT cycle before the response is declared lost
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] csr_idx_q, csr_idx_d;
    logic [REG_W-1:0] imm_q, imm_d;
    logic [REG_W-1:0] rd_q, rd_d;
    logic             imm_sel_q, imm_sel_d;
    logic [1:0]       op_q, op_d;
    logic             write_q, write_d;
    logic             read_q, read_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [XLEN-1:0]  wb_data_q, wb_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;

    // Request decode
    logic [1:0] op_in;
    logic       is_rw_in, write_in, read_in, bad_in;

    assign op_in    = bus.i_funct3[1:0];
    assign is_rw_in = (op_in == OP_RW);
    assign write_in = is_rw_in || (bus.i_rs1_idx != '0);
    assign read_in  = (bus.i_rd_idx != '0) || !is_rw_in;
    // funct3 x00 is not a CSR op; writing a read-only CSR (idx[11:10]==11) traps
    assign bad_in   = (op_in == 2'b00) || (write_in && (bus.i_csr_idx[11:10] == 2'b11));

    // State and datapath registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            csr_idx_q <= '0;
            imm_q     <= '0;
            rd_q      <= '0;
            imm_sel_q <= 1'b0;
            op_q      <= '0;
            write_q   <= 1'b0;
            read_q    <= 1'b0;
            wdata_q   <= '0;
            wb_data_q <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            csr_idx_q <= csr_idx_d;
            imm_q     <= imm_d;
            rd_q      <= rd_d;
            imm_sel_q <= imm_sel_d;
            op_q      <= op_d;
            write_q   <= write_d;
            read_q    <= read_d;
            wdata_q   <= wdata_d;
            wb_data_q <= wb_data_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        csr_idx_d = csr_idx_q;
        imm_d     = imm_q;
        rd_d      = rd_q;
        imm_sel_d = imm_sel_q;
        op_d      = op_q;
        write_d   = write_q;
        read_d    = read_q;
        wdata_d   = wdata_q;
        wb_data_d = wb_data_q;
        cnt_d     = cnt_q;
        illegal_d = 1'b0;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    csr_idx_d = bus.i_csr_idx;
                    imm_d     = bus.i_rs1_idx;
                    rd_d      = bus.i_rd_idx;
                    imm_sel_d = bus.i_funct3[2];
                    op_d      = op_in;
                    write_d   = write_in;
                    read_d    = read_in;
                    wdata_d   = bus.i_rs1_data;
                    cnt_d     = '0;
                    if (bad_in) begin
                        illegal_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            WAIT: begin
                // Write-only ops expect no data: one WAIT cycle, response ignored
                if (!read_q) begin
                    state_d = IDLE;
                end else if (bus.i_csr_read) begin
                    wb_data_d = bus.i_csr_data;
                    state_d   = (rd_q != '0) ? WB : IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WB: begin
                if (bus.i_wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    logic issue;
    assign issue = (state_q == ISSUE);

    assign bus.o_ready       = (state_q == IDLE);
    assign bus.o_busy        = (state_q != IDLE);
    assign bus.o_csr_idx     = csr_idx_q;
    assign bus.o_csr_imm     = imm_q;
    assign bus.o_csr_imm_sel = imm_sel_q;
    assign bus.o_csr_wdata   = wdata_q;
    assign bus.o_csr_write   = issue && write_q && (op_q == OP_RW);
    assign bus.o_csr_set     = issue && write_q && (op_q == OP_RS);
    assign bus.o_csr_clear   = issue && write_q && (op_q == OP_RC);
    assign bus.o_csr_read    = issue && read_q;
    assign bus.o_wb_valid    = (state_q == WB);
    assign bus.o_wb_rd       = rd_q;
    assign bus.o_wb_data     = wb_data_q;
    assign bus.o_illegal     = illegal_q;
    assign bus.o_timeout     = timeout_q;
endmodule

// File: tb/tb_rv_csr_req.sv
// Directed bench for rv_csr_req: expected CSR issues and output events are queued
// when a request is driven and compared when the DUT produces them.
module tb_rv_csr_req;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rv_csr_req_if bus ();

    rv_csr_req #(.RSP_TIMEOUT(4)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    typedef struct packed {
        logic [11:0] idx;
        logic [3:0]  st;     // {write, set, clear, read}
        logic [31:0] wdata;
        logic [4:0]  imm;
        logic        sel;
    } iss_t;

    typedef struct packed {
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] data;
    } ev_t;

    localparam logic [1:0] EV_WB  = 2'd0;
    localparam logic [1:0] EV_ILL = 2'd1;
    localparam logic [1:0] EV_TO  = 2'd2;

    iss_t iss_q[$];
    ev_t  ev_q[$];

    int errors = 0;
    int checks = 0;

    // Environment knobs
    int          rsp_lat   = 1;
    bit          rsp_en    = 1'b1;
    logic [31:0] rsp_data  = '0;
    bit          force_read = 1'b0;
    int          wb_hold   = 0;
    int          resp_wait = -1;

    iss_t obs_i, exp_i;
    ev_t  obs_e, exp_e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_iss(input logic [11:0] idx, input logic [3:0] st,
                            input logic [31:0] wdata, input logic [4:0] imm, input logic sel);
        iss_t t;
        t.idx = idx; t.st = st; t.wdata = wdata; t.imm = imm; t.sel = sel;
        iss_q.push_back(t);
    endtask

    task automatic push_ev(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] data);
        ev_t e;
        e.kind = kind; e.rd = rd; e.data = data;
        ev_q.push_back(e);
    endtask

    // Drive one request and hold it until accepted
    task automatic send(input logic [2:0] f3, input logic [11:0] idx, input logic [4:0] rs1,
                        input logic [31:0] data, input logic [4:0] rd);
        int k;
        @(negedge clk);
        bus.i_valid    = 1'b1;
        bus.i_funct3   = f3;
        bus.i_csr_idx  = idx;
        bus.i_rs1_idx  = rs1;
        bus.i_rs1_data = data;
        bus.i_rd_idx   = rd;
        k = 0;
        while (!bus.o_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("accept_ready", 64'(bus.o_ready), 64'(1));
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    // Busy cycles after accept until o_ready returns
    task automatic wait_idle(input string tag, input int exp_n);
        int n;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (bus.o_ready) break;
            n++;
        end
        chk(tag, 64'(n), 64'(exp_n));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 64'(bus.o_ready), 64'(1));
        chk({tag, "_flags"}, 64'({bus.o_busy, bus.o_csr_write, bus.o_csr_set, bus.o_csr_clear,
                                  bus.o_csr_read, bus.o_wb_valid, bus.o_illegal, bus.o_timeout}), 64'(0));
        chk({tag, "_idx"},   64'(bus.o_csr_idx), 64'(0));
        chk({tag, "_wdata"}, 64'(bus.o_csr_wdata), 64'(0));
        chk({tag, "_wb"},    64'({bus.o_wb_rd, bus.o_wb_data}), 64'(0));
    endtask

    // CSR file responder, writeback sink and output monitor
    always @(negedge clk) begin
        bus.i_csr_read = 1'b0;
        bus.i_csr_data = 32'hFFFF_FFFF;
        bus.i_wb_ready = 1'b0;
        if (rst) begin
            resp_wait = -1;
        end else begin
            if (force_read) begin
                bus.i_csr_read = 1'b1;
                bus.i_csr_data = 32'h0BAD_0BAD;
            end
            if (resp_wait == 0) begin
                bus.i_csr_read = 1'b1;
                bus.i_csr_data = rsp_data;
                resp_wait = -1;
            end else if (resp_wait > 0) begin
                resp_wait--;
            end
            if (bus.o_csr_read && rsp_en) resp_wait = rsp_lat - 1;

            if (bus.o_wb_valid) begin
                if (wb_hold > 0) wb_hold--;
                else bus.i_wb_ready = 1'b1;
            end

            if (bus.o_csr_write || bus.o_csr_set || bus.o_csr_clear || bus.o_csr_read) begin
                chk("issue_expected", 64'(iss_q.size() != 0), 64'(1));
                if (iss_q.size() != 0) begin
                    exp_i = iss_q.pop_front();
                    obs_i.idx   = bus.o_csr_idx;
                    obs_i.st    = {bus.o_csr_write, bus.o_csr_set, bus.o_csr_clear, bus.o_csr_read};
                    obs_i.wdata = bus.o_csr_wdata;
                    obs_i.imm   = bus.o_csr_imm;
                    obs_i.sel   = bus.o_csr_imm_sel;
                    chk("issue", 64'(obs_i), 64'(exp_i));
                    chk("issue_busy", 64'(bus.o_busy), 64'(1));
                end
            end

            if (bus.o_illegal || bus.o_timeout || (bus.o_wb_valid && bus.i_wb_ready)) begin
                chk("event_expected", 64'(ev_q.size() != 0), 64'(1));
                if (ev_q.size() != 0) begin
                    exp_e = ev_q.pop_front();
                    obs_e.kind = bus.o_illegal ? EV_ILL : (bus.o_timeout ? EV_TO : EV_WB);
                    obs_e.rd   = (obs_e.kind == EV_WB) ? bus.o_wb_rd : 5'd0;
                    obs_e.data = (obs_e.kind == EV_WB) ? bus.o_wb_data : 32'd0;
                    chk("event", 64'(obs_e), 64'(exp_e));
                end
            end else if (bus.o_wb_valid && ev_q.size() != 0) begin
                chk("wb_stable", 64'({bus.o_wb_rd, bus.o_wb_data}), 64'({ev_q[0].rd, ev_q[0].data}));
            end
        end
    end

    initial begin
        bus.i_valid = 1'b0; bus.i_funct3 = '0; bus.i_csr_idx = '0;
        bus.i_rs1_idx = '0; bus.i_rs1_data = '0; bus.i_rd_idx = '0;
        bus.i_csr_read = 1'b0; bus.i_csr_data = '0; bus.i_wb_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        // CSRRS 0x300, rs1=5 -> set+read, writeback of old value
        rsp_lat = 1; rsp_data = 32'h0000_1800;
        push_iss(12'h300, 4'b0101, 32'h8, 5'd5, 1'b0);
        push_ev(EV_WB, 5'd3, 32'h0000_1800);
        send(3'b010, 12'h300, 5'd5, 32'h8, 5'd3);
        wait_idle("lat_csrrs", 3);

        // CSRRW rd=0 -> write only, single WAIT cycle, stray i_csr_read ignored
        force_read = 1'b1;
        push_iss(12'h341, 4'b1000, 32'h100, 5'd7, 1'b0);
        send(3'b001, 12'h341, 5'd7, 32'h100, 5'd0);
        wait_idle("lat_csrrw_rd0", 2);
        force_read = 1'b0;

        // CSRRSI uimm=0 on read-only CSR -> read only
        rsp_data = 32'hCAFE_0001;
        push_iss(12'hF14, 4'b0001, 32'hDEAD, 5'd0, 1'b1);
        push_ev(EV_WB, 5'd1, 32'hCAFE_0001);
        send(3'b110, 12'hF14, 5'd0, 32'hDEAD, 5'd1);
        wait_idle("lat_csrrsi", 3);

        // CSRRWI on read-only CSR -> illegal
        push_ev(EV_ILL, 5'd0, 32'd0);
        send(3'b101, 12'hF14, 5'd3, 32'h1, 5'd2);
        wait_idle("lat_ill_ro", 0);

        // Reserved funct3 encodings -> illegal
        push_ev(EV_ILL, 5'd0, 32'd0);
        send(3'b100, 12'h300, 5'd1, 32'h1, 5'd1);
        wait_idle("lat_ill_f3_100", 0);
        push_ev(EV_ILL, 5'd0, 32'd0);
        send(3'b000, 12'h300, 5'd1, 32'h1, 5'd1);
        wait_idle("lat_ill_f3_000", 0);

        // CSRRC with rs1!=0 on read-only CSR -> illegal; with rs1=0 -> legal read
        push_ev(EV_ILL, 5'd0, 32'd0);
        send(3'b011, 12'hC00, 5'd4, 32'h77, 5'd4);
        wait_idle("lat_ill_rc", 0);
        rsp_data = 32'h0000_ABCD;
        push_iss(12'hC00, 4'b0001, 32'h77, 5'd0, 1'b0);
        push_ev(EV_WB, 5'd4, 32'h0000_ABCD);
        send(3'b011, 12'hC00, 5'd0, 32'h77, 5'd4);
        wait_idle("lat_rc_ro_read", 3);

        // CSRRCI, response in the last WAIT cycle before timeout
        rsp_lat = 3; rsp_data = 32'h1234_5678;
        push_iss(12'h305, 4'b0011, 32'h11, 5'd9, 1'b1);
        push_ev(EV_WB, 5'd6, 32'h1234_5678);
        send(3'b111, 12'h305, 5'd9, 32'h11, 5'd6);
        wait_idle("lat_late_rsp", 5);

        // No response -> timeout pulse, no writeback
        rsp_en = 1'b0;
        push_iss(12'h300, 4'b0001, 32'h0, 5'd0, 1'b0);
        push_ev(EV_TO, 5'd0, 32'd0);
        send(3'b010, 12'h300, 5'd0, 32'h0, 5'd5);
        wait_idle("lat_timeout", 4);
        rsp_en = 1'b1; rsp_lat = 1;

        // Read with rd=0 -> data captured, no writeback
        rsp_data = 32'h5555_AAAA;
        push_iss(12'h300, 4'b0001, 32'h0, 5'd0, 1'b0);
        send(3'b010, 12'h300, 5'd0, 32'h0, 5'd0);
        wait_idle("lat_read_rd0", 2);

        // Writeback back-pressure for 3 cycles
        rsp_data = 32'h0000_1234; wb_hold = 3;
        push_iss(12'h340, 4'b1001, 32'h55, 5'd1, 1'b0);
        push_ev(EV_WB, 5'd7, 32'h0000_1234);
        send(3'b001, 12'h340, 5'd1, 32'h55, 5'd7);
        wait_idle("lat_wb_hold", 6);

        // Reset in the middle of WAIT
        rsp_en = 1'b0;
        push_iss(12'h300, 4'b0101, 32'h3, 5'd2, 1'b0);
        send(3'b010, 12'h300, 5'd2, 32'h3, 5'd8);
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", 64'(bus.o_busy), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rsp_en = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_reset_ready", 64'(bus.o_ready), 64'(1));

        chk("iss_q_drained", 64'(iss_q.size()), 64'(0));
        chk("ev_q_drained", 64'(ev_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
